// File: rtl/mipsfpga_disp_sched_if.sv
// Register-bus bundle for the display scheduler; shares the GPIO slave's HSEL decode.
interface mipsfpga_disp_sched_if;
  logic [3:0]  HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HRDATA;

  modport master (output HADDR, HWDATA, HWRITE, HSEL, input HRDATA);
  modport slave  (input HADDR, HWDATA, HWRITE, HSEL, output HRDATA);
endinterface

// File: rtl/mipsfpga_disp_sched.sv
// Sword-board display controller: one serial shift engine shared round-robin
// between the 64-bit 7-segment chain and the 16-bit LED chain.
module mipsfpga_disp_sched #(
  parameter int CLK_DIV        = 2,
  parameter int REFRESH_CYCLES = 50000000
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  mipsfpga_disp_sched_if.slave bus,
  output logic                 seg_clk,
  output logic                 seg_do,
  output logic                 seg_pen,
  output logic                 led_clk,
  output logic                 led_do,
  output logic                 led_pen
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(REFRESH_CYCLES);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SLO, SHI, LATCH} state_t;

  state_t        state, state_n;
  logic [31:0]   seg_lo, seg_hi;
  logic [15:0]   led_reg;
  logic          auto_en, seg_pend, led_pend, last_seg, act_seg;
  logic [TW-1:0] timer;
  logic [DW-1:0] div_cnt;
  logic [6:0]    bit_cnt;
  logic [63:0]   shreg;
  logic          wr, wrap, div_done, grant_seg, busy;
  logic          sclk, sdo, spen;
  logic          unused_addr;

  assign wr          = bus.HSEL & bus.HWRITE;
  assign wrap        = auto_en && (timer == TMR_LAST);
  assign div_done    = (div_cnt == DIV_LAST);
  assign grant_seg   = seg_pend & (~led_pend | ~last_seg);
  assign busy        = (state != IDLE);
  assign unused_addr = ^bus.HADDR[1:0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      seg_lo  <= '0;
      seg_hi  <= '0;
      led_reg <= '0;
      auto_en <= 1'b0;
    end else if (wr) begin
      case (bus.HADDR[3:2])
        2'd0: seg_lo  <= bus.HWDATA;
        2'd1: seg_hi  <= bus.HWDATA;
        2'd2: led_reg <= bus.HWDATA[15:0];
        2'd3: auto_en <= bus.HWDATA[0];
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     timer <= '0;
    else if (!auto_en || wrap) timer <= '0;
    else              timer <= timer + 1'b1;
  end

  // Setting beats clearing, so a write landing on the LOAD cycle still queues a refresh.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      seg_pend <= 1'b0;
      led_pend <= 1'b0;
    end else begin
      seg_pend <= (wr && !bus.HADDR[3]) || wrap ||
                  (seg_pend && !(state == LOAD && act_seg));
      led_pend <= (wr && bus.HADDR[3:2] == 2'd2) || wrap ||
                  (led_pend && !(state == LOAD && !act_seg));
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    sclk    = 1'b0;
    sdo     = 1'b0;
    spen    = 1'b0;
    case (state)
      IDLE:  if (seg_pend || led_pend) state_n = LOAD;
      LOAD:  state_n = SLO;
      SLO: begin
        sdo = shreg[63];
        if (div_done) state_n = SHI;
      end
      SHI: begin
        sclk = 1'b1;
        sdo  = shreg[63];
        if (div_done) state_n = (bit_cnt == 7'd1) ? LATCH : SLO;
      end
      LATCH: begin
        spen = 1'b1;
        if (div_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    seg_clk = act_seg & sclk;
    seg_do  = act_seg & sdo;
    seg_pen = act_seg & spen;
    led_clk = ~act_seg & sclk;
    led_do  = ~act_seg & sdo;
    led_pen = ~act_seg & spen;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      act_seg  <= 1'b0;
      last_seg <= 1'b0;
    end else begin
      if (state_n != state || state == IDLE || state == LOAD) div_cnt <= '0;
      else                                                   div_cnt <= div_cnt + 1'b1;
      case (state)
        IDLE: if (seg_pend || led_pend) begin
          act_seg  <= grant_seg;
          last_seg <= grant_seg;
        end
        LOAD: begin
          // LED data is left-justified so both chains shift out of bit 63.
          shreg   <= act_seg ? {seg_hi, seg_lo} : {led_reg, 48'd0};
          bit_cnt <= act_seg ? 7'd64 : 7'd16;
        end
        SHI: if (div_done) begin
          shreg   <= {shreg[62:0], 1'b0};
          bit_cnt <= bit_cnt - 7'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus.HADDR[3:2])
      2'd0:    bus.HRDATA = seg_lo;
      2'd1:    bus.HRDATA = seg_hi;
      2'd2:    bus.HRDATA = {16'd0, led_reg};
      default: bus.HRDATA = {27'd0, auto_en, act_seg, led_pend, seg_pend, busy};
    endcase
  end
endmodule

// File: tb/tb_mipsfpga_disp_sched.sv
// Directed bench for mipsfpga_disp_sched: transfer-level reference model compared
// every cycle, plus literal expectations on captured serial streams and status.
module tb_mipsfpga_disp_sched;
  localparam int D  = 2;
  localparam int RC = 10;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic seg_clk, seg_do, seg_pen, led_clk, led_do, led_pen;

  mipsfpga_disp_sched_if bus();

  mipsfpga_disp_sched #(.CLK_DIV(D), .REFRESH_CYCLES(RC)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .seg_clk(seg_clk), .seg_do(seg_do), .seg_pen(seg_pen),
    .led_clk(led_clk), .led_do(led_do), .led_pen(led_pen)
  );

  always #5 HCLK = ~HCLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: registers, pendings, timer and the in-flight transfer as
  // (chain, data, length, cycles elapsed since the load cycle).
  logic [31:0] m_lo, m_hi;
  logic [15:0] m_led;
  logic        m_auto, m_sp, m_lp, m_last_seg, m_is_seg, m_active;
  int          m_timer, m_k, m_n;
  logic [63:0] m_data;

  // Observed-stream collectors.
  logic [63:0] seg_bits;
  logic [31:0] led_bits;
  int          seg_nclk, led_nclk, seg_pen_cyc, led_pen_cyc, busy_cyc;
  logic [63:0] ord;
  int          nord;
  logic        p_sc, p_lc, p_sp, p_lp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lo = '0; m_hi = '0; m_led = '0;
    m_auto = 0; m_sp = 0; m_lp = 0; m_last_seg = 0; m_is_seg = 0; m_active = 0;
    m_timer = 0; m_k = 0; m_n = 0; m_data = '0;
  endtask

  task automatic model_step();
    logic w, wrap, clr_s, clr_l, set_s, set_l;
    logic [1:0] a;
    w = bus.HSEL & bus.HWRITE;
    a = bus.HADDR[3:2];
    wrap = m_auto && (m_timer == RC - 1);
    clr_s = 0; clr_l = 0;
    if (m_active) begin
      if (m_k == 0) begin
        m_data = m_is_seg ? {m_hi, m_lo} : {m_led, 48'd0};
        m_n = m_is_seg ? 64 : 16;
        if (m_is_seg) clr_s = 1; else clr_l = 1;
      end
      m_k++;
      if (m_k == 1 + 2 * m_n * D + D) m_active = 0;
    end else if (m_sp || m_lp) begin
      m_is_seg = m_sp && (!m_lp || !m_last_seg);
      m_last_seg = m_is_seg;
      m_active = 1;
      m_k = 0;
    end
    set_s = (w && a < 2) || wrap;
    set_l = (w && a == 2) || wrap;
    m_sp = set_s ? 1'b1 : (clr_s ? 1'b0 : m_sp);
    m_lp = set_l ? 1'b1 : (clr_l ? 1'b0 : m_lp);
    m_timer = (!m_auto || wrap) ? 0 : m_timer + 1;
    if (w) begin
      case (a)
        2'd0: m_lo = bus.HWDATA;
        2'd1: m_hi = bus.HWDATA;
        2'd2: m_led = bus.HWDATA[15:0];
        2'd3: m_auto = bus.HWDATA[0];
      endcase
    end
  endtask

  function automatic logic [37:0] exp_vec();
    logic [31:0] rd;
    logic c, d, p;
    int j, b;
    case (bus.HADDR[3:2])
      2'd0:    rd = m_lo;
      2'd1:    rd = m_hi;
      2'd2:    rd = {16'd0, m_led};
      default: rd = {27'd0, m_auto, m_is_seg, m_lp, m_sp, m_active};
    endcase
    c = 0; d = 0; p = 0;
    if (m_active && m_k > 0) begin
      if (m_k <= 2 * m_n * D) begin
        j = m_k - 1;
        b = j / (2 * D);
        c = (j % (2 * D)) >= D;
        d = m_data[63 - b];
      end else p = 1;
    end
    return m_is_seg ? {rd, c, d, p, 3'b000} : {rd, 3'b000, c, d, p};
  endfunction

  task automatic tick();
    @(posedge HCLK);
    if (!HRESETn) model_reset(); else model_step();
    #1;
    check("cycle", {26'd0, bus.HRDATA, seg_clk, seg_do, seg_pen, led_clk, led_do, led_pen},
          {26'd0, exp_vec()});
    if (seg_clk && !p_sc) begin seg_bits = {seg_bits[62:0], seg_do}; seg_nclk++; end
    if (led_clk && !p_lc) begin led_bits = {led_bits[30:0], led_do}; led_nclk++; end
    if (seg_pen) seg_pen_cyc++;
    if (led_pen) led_pen_cyc++;
    if (seg_pen && !p_sp && nord < 64) begin ord[nord] = 1'b1; nord++; end
    if (led_pen && !p_lp && nord < 64) begin ord[nord] = 1'b0; nord++; end
    if (bus.HADDR[3:2] == 2'd3 && bus.HRDATA[0]) busy_cyc++;
    p_sc = seg_clk; p_lc = led_clk; p_sp = seg_pen; p_lp = led_pen;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    bus.HSEL = 1; bus.HWRITE = 1; bus.HADDR = addr; bus.HWDATA = data;
    tick();
    bus.HSEL = 0; bus.HWRITE = 0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((m_active || m_sp || m_lp) && n < max_cyc) begin tick(); n++; end
    if (n >= max_cyc) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    int l0, s0, b0, lp0, sp0, n0, n;
    seg_bits = '0; led_bits = '0; ord = '0; nord = 0;
    seg_nclk = 0; led_nclk = 0; seg_pen_cyc = 0; led_pen_cyc = 0; busy_cyc = 0;
    p_sc = 0; p_lc = 0; p_sp = 0; p_lp = 0;
    bus.HSEL = 0; bus.HWRITE = 0; bus.HADDR = 4'hC; bus.HWDATA = '0;
    model_reset();
    repeat (3) tick();
    HRESETn = 1;
    repeat (2) tick();
    check("reset_status", {32'd0, bus.HRDATA}, 64'd0);
    bus.HADDR = 4'h0; #1;
    check("reset_seg_lo", {32'd0, bus.HRDATA}, 64'd0);

    // Single LED transfer
    l0 = led_nclk; s0 = seg_nclk; b0 = busy_cyc; lp0 = led_pen_cyc;
    wr(4'h8, 32'h0000A5C3);
    bus.HADDR = 4'hC;
    wait_idle(500);
    check("led_clk_edges", led_nclk - l0, 16);
    check("led_stream", {48'd0, led_bits[15:0]}, 64'hA5C3);
    check("led_busy_cycles", busy_cyc - b0, 67);
    check("led_pen_cycles", led_pen_cyc - lp0, 2);
    check("seg_idle_during_led", seg_nclk - s0, 0);

    // Seg transfer then LED, with status mid-seg
    s0 = seg_nclk; l0 = led_nclk; sp0 = seg_pen_cyc;
    wr(4'h0, 32'h12345678);
    wr(4'h4, 32'h9ABCDEF0);
    wr(4'h8, 32'h000000FF);
    bus.HADDR = 4'hC;
    repeat (5) tick();
    check("status_mid_seg", {59'd0, bus.HRDATA[4:0]}, 64'h0D);
    wait_idle(2000);
    check("seg_clk_edges", seg_nclk - s0, 64);
    check("seg_stream", seg_bits, 64'h9ABCDEF012345678);
    check("seg_pen_cycles", seg_pen_cyc - sp0, 2);
    check("led2_stream", {48'd0, led_bits[15:0]}, 64'h00FF);
    check("seg_then_led", {62'd0, ord[nord-2], ord[nord-1]}, 64'b10);

    // Auto refresh from reset: seg, LED, seg
    HRESETn = 0; model_reset();
    repeat (2) tick();
    HRESETn = 1;
    tick();
    n0 = nord;
    wr(4'hC, 32'h1);
    bus.HADDR = 4'hC;
    repeat (700) tick();
    check("auto_rr_order", {61'd0, ord[n0], ord[n0+1], ord[n0+2]}, 64'b101);
    wr(4'hC, 32'h0);
    bus.HADDR = 4'hC;
    wait_idle(2000);

    // LED rewritten mid-transfer
    l0 = led_nclk;
    wr(4'h8, 32'h0000FFFF);
    bus.HADDR = 4'hC;
    repeat (30) tick();
    wr(4'h8, 32'h00000001);
    bus.HADDR = 4'hC;
    wait_idle(500);
    check("led_rewrite_edges", led_nclk - l0, 32);
    check("led_rewrite_stream", {32'd0, led_bits}, 64'hFFFF0001);

    // Async reset mid seg stream
    s0 = seg_nclk;
    wr(4'h0, 32'h0F0F0F0F);
    bus.HADDR = 4'hC;
    n = 0;
    while (seg_nclk - s0 < 20 && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      vectors++; miscompares++;
      $display("FAIL seg_bit20_wait: saw %0d edges, required 20", seg_nclk - s0);
    end
    sp0 = seg_pen_cyc;
    tick();
    #2 HRESETn = 0; model_reset();
    #1;
    check("reset_outs", {58'd0, seg_clk, seg_do, seg_pen, led_clk, led_do, led_pen}, 64'd0);
    check("reset_status_now", {32'd0, bus.HRDATA}, 64'd0);
    repeat (2) tick();
    HRESETn = 1;
    repeat (20) tick();
    check("no_seg_pen_after_abort", seg_pen_cyc - sp0, 0);
    check("no_restart", seg_nclk - s0, 20);
    check("status_after_abort", {32'd0, bus.HRDATA}, 64'd0);

    // Read-back
    wr(4'hC, 32'h1);
    bus.HADDR = 4'hC; #1;
    check("ctrl_readback_bit4", {63'd0, bus.HRDATA[4]}, 64'd1);
    wr(4'hC, 32'h0);
    wr(4'h8, 32'h00001234);
    bus.HADDR = 4'h8; #1;
    check("led_readback", {32'd0, bus.HRDATA}, 64'h00001234);
    bus.HADDR = 4'hC;
    wait_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
